// File: rtl/func_rr_arbiter.sv
// func_rr_arbiter
//   Round-robin arbiter that shares one functional unit among 8 requesters.
//   A grant is held until the unit pulses done. The winner then moves to
//   lowest priority. At least one IDLE cycle always separates two grants.
//
//   Optional build macro: ARB_TIMEOUT_EN
//     Adds a watchdog that force-releases a grant after TIMEOUT_CYC BUSY
//     cycles without done, and pulses timeout_o for one cycle. Without the
//     macro, timeout_o is tied low and BUSY waits for done indefinitely.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no grant held; req_i is arbitrated every cycle
//   BUSY  | one requester owns the unit; grant/opcode frozen until release
module func_rr_arbiter #(
  parameter int N_REQ = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] opcode_o,
  output logic             busy_o,
  output logic             timeout_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] opcode_q, opcode_d;
  logic [N_REQ-1:0] grant_q, grant_d;

  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             wdog_expire;

  // Rotating priority search: first set request starting at ptr_q, wrapping mod N_REQ
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = ptr_q;
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 16;

  logic [4:0] wdog_q, wdog_d;
  logic       timeout_q, timeout_d;

  // The edge that would take the count to TIMEOUT_CYC is the release edge,
  // so a grant stays visible for exactly TIMEOUT_CYC cycles.
  assign wdog_expire = (state_q == ST_BUSY) && (wdog_q == 5'(TIMEOUT_CYC - 1));

  // Watchdog next state: held at zero outside BUSY, so every grant starts from zero
  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
    if (state_q == ST_IDLE) begin
      wdog_d = '0;
    end else if (done_i) begin
      // A done arriving on the expiry edge takes precedence: no timeout pulse.
      wdog_d = '0;
    end else if (wdog_expire) begin
      wdog_d    = '0;
      timeout_d = 1'b1;
    end else begin
      wdog_d = wdog_q + 5'd1;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign wdog_expire = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  // FSM next-state and grant/opcode/pointer update
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    opcode_d = opcode_q;
    grant_d  = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        // done_i is deliberately not looked at here.
        grant_d = '0;
        if (win_found) begin
          grant_d  = N_REQ'(1) << win_idx;
          opcode_d = win_idx;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // req_i is ignored while busy, even if the winner withdraws.
        if (done_i || wdog_expire) begin
          grant_d = '0;
          ptr_d   = opcode_q + IDX_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      opcode_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      opcode_q <= opcode_d;
      grant_q  <= grant_d;
    end
  end

  // opcode_o keeps its last value through IDLE; only grant_o clears.
  assign grant_o       = grant_q;
  assign opcode_o      = opcode_q;
  assign grant_valid_o = (state_q == ST_BUSY);
  assign busy_o        = (state_q == ST_BUSY);

endmodule

// File: tb/tb_func_rr_arbiter.sv
// Directed bench for func_rr_arbiter. Inputs change and outputs are sampled 1ns after each rising edge.
module tb_func_rr_arbiter;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] req_i;
  logic       done_i;
  logic [7:0] grant_o;
  logic       grant_valid_o;
  logic [2:0] opcode_o;
  logic       busy_o;
  logic       timeout_o;

  int total = 0;
  int bad   = 0;

  func_rr_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .done_i        (done_i),
    .grant_o       (grant_o),
    .grant_valid_o (grant_valid_o),
    .opcode_o      (opcode_o),
    .busy_o        (busy_o),
    .timeout_o     (timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [7:0] g, input logic [2:0] op, input logic v);
    chk({tag, ".grant"}, 32'(grant_o), 32'(g));
    chk({tag, ".opcode"}, 32'(opcode_o), 32'(op));
    chk({tag, ".valid"}, 32'(grant_valid_o), 32'(v));
    chk({tag, ".busy"}, 32'(busy_o), 32'(v));
  endtask

  initial begin
    rst_i  = 1'b1;
    req_i  = 8'h00;
    done_i = 1'b0;
    step();
    step();
    chk_grant("reset", 8'h00, 3'd0, 1'b0);
    chk("reset.timeout", 32'(timeout_o), 32'd0);
    rst_i = 1'b0;
    step();
    chk_grant("idle_noreq", 8'h00, 3'd0, 1'b0);

    // Single requester 2; release moves ptr to 3
    req_i = 8'b0000_0100;
    step();
    chk_grant("t1.grant", 8'b0000_0100, 3'd2, 1'b1);
    req_i  = 8'h00;
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk_grant("t1.release", 8'h00, 3'd2, 1'b0);

    // done while IDLE must do nothing
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk_grant("idle_done", 8'h00, 3'd2, 1'b0);

    // From ptr=3, requesters 7 and 0: 7 first, then 0
    req_i = 8'b1000_0001;
    step();
    chk_grant("t3.first", 8'b1000_0000, 3'd7, 1'b1);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk_grant("t3.gap", 8'h00, 3'd7, 1'b0);
    step();
    chk_grant("t3.second", 8'b0000_0001, 3'd0, 1'b1);
    req_i  = 8'h00;
    done_i = 1'b1;
    step();
    done_i = 1'b0;

    // ptr=1: grant 5, winner drops and req 1 appears; grant holds until done
    req_i = 8'b0010_0000;
    step();
    chk_grant("t4.grant", 8'b0010_0000, 3'd5, 1'b1);
    req_i = 8'b0000_0010;
    step();
    chk_grant("t4.hold1", 8'b0010_0000, 3'd5, 1'b1);
    step();
    chk_grant("t4.hold2", 8'b0010_0000, 3'd5, 1'b1);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk_grant("t4.release", 8'h00, 3'd5, 1'b0);
    step();
    chk_grant("t4.next", 8'b0000_0010, 3'd1, 1'b1);
    req_i  = 8'h00;
    done_i = 1'b1;
    step();
    done_i = 1'b0;

    // ptr=2: grant 6, then async reset mid-BUSY with a done pulse during reset
    req_i = 8'b0100_0000;
    step();
    chk_grant("t5.grant", 8'b0100_0000, 3'd6, 1'b1);
    rst_i = 1'b1;
    #1;
    chk_grant("t5.async", 8'h00, 3'd0, 1'b0);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    rst_i  = 1'b0;
    chk_grant("t5.inreset", 8'h00, 3'd0, 1'b0);
    req_i = 8'hFF;
    step();
    chk_grant("t5.after", 8'b0000_0001, 3'd0, 1'b1);

    // req=FF held: strict rotation 1..7,0, done two cycles after each grant
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_grant($sformatf("t2.hold%0d", k), 8'(1) << ((k - 1) % 8), 3'((k - 1) % 8), 1'b1);
      done_i = 1'b1;
      step();
      done_i = 1'b0;
      chk($sformatf("t2.gap%0d", k), 32'(grant_valid_o), 32'd0);
      step();
      chk_grant($sformatf("t2.rot%0d", k), 8'(1) << (k % 8), 3'(k % 8), 1'b1);
    end
    req_i  = 8'h00;
    done_i = 1'b1;
    step();
    done_i = 1'b0;

    // ptr=1: requester 3 with no done
    req_i = 8'b0000_1000;
    step();
    chk_grant("t6.grant", 8'b0000_1000, 3'd3, 1'b1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      step();
      chk($sformatf("t6.held%0d", i), 32'(grant_o), 32'h08);
      chk($sformatf("t6.noto%0d", i), 32'(timeout_o), 32'd0);
    end
    step();
    chk_grant("t6.forced", 8'h00, 3'd3, 1'b0);
    chk("t6.timeout", 32'(timeout_o), 32'd1);
    req_i = 8'b0001_1000;
    step();
    chk("t6.pulse_end", 32'(timeout_o), 32'd0);
    chk_grant("t6.ptr4", 8'b0001_0000, 3'd4, 1'b1);
    // done on the expiry edge wins
    for (int i = 1; i <= 15; i++) begin
      step();
    end
    chk("t6b.held", 32'(grant_o), 32'h10);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk_grant("t6b.release", 8'h00, 3'd4, 1'b0);
    chk("t6b.notimeout", 32'(timeout_o), 32'd0);
    req_i = 8'h00;
    step();
`else
    for (int i = 1; i <= 120; i++) begin
      step();
      chk($sformatf("t6.held%0d", i), 32'(grant_o), 32'h08);
      chk($sformatf("t6.noto%0d", i), 32'(timeout_o), 32'd0);
    end
    chk_grant("t6.still", 8'b0000_1000, 3'd3, 1'b1);
    req_i  = 8'h00;
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk_grant("t6.release", 8'h00, 3'd3, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
